// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: D-pad bit indices, SOCD mode
// encodings, the axis-owner enum and the per-axis ownership/resolution helpers.
package btn_cond_pkg;

   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DOWN  = 3;

   localparam logic [1:0] SOCD_NEUTRAL = 2'b00;
   localparam logic [1:0] SOCD_LAST    = 2'b01;
   localparam logic [1:0] SOCD_FIRST   = 2'b10;
   localparam logic [1:0] SOCD_UPPRI   = 2'b11;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_A    = 2'b01,
      OWN_B    = 2'b10
   } owner_e;

   // B is the direction that wins a same-cycle double press (DOWN, RIGHT)
   function automatic owner_e owner_next(input logic a, input logic b,
                                         input logic rise_a, input logic rise_b,
                                         input logic [1:0] mode, input owner_e own);
      owner_e nx;
      if (!a && !b)              nx = OWN_NONE;
      else if (a && !b)          nx = OWN_A;
      else if (!a && b)          nx = OWN_B;
      else if (mode == SOCD_FIRST) nx = (own == OWN_NONE) ? OWN_B : own;
      else if (rise_b)           nx = OWN_B;
      else if (rise_a)           nx = OWN_A;
      else                       nx = (own == OWN_NONE) ? OWN_B : own;
      return nx;
   endfunction

   // Returns {b_out, a_out}; only a conflicting axis is touched
   function automatic logic [1:0] axis_resolve(input logic a, input logic b,
                                               input owner_e own, input logic [1:0] mode,
                                               input logic is_vert);
      logic [1:0] r;
      if (!(a && b)) begin
         r = {b, a};
      end else begin
         case (mode)
            SOCD_NEUTRAL:          r = 2'b00;
            SOCD_LAST, SOCD_FIRST: r = {own == OWN_B, own == OWN_A};
            SOCD_UPPRI:            r = {1'b0, is_vert};
            default:               r = 2'b00;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle. Turbo controls exist only when
// BTN_TURBO_EN is defined.
interface btn_conditioner_if #(
   parameter int NUM_BTN = 8
`ifdef BTN_TURBO_EN
   , parameter int TURBO_W = 16
`endif
);
   logic [NUM_BTN-1:0] btn_raw;
   logic               gate;
   logic [1:0]         socd_mode;
   logic               no_diagonal;
`ifdef BTN_TURBO_EN
   logic [NUM_BTN-1:0] turbo_mask;
   logic [TURBO_W-1:0] turbo_half;
`endif
   logic [NUM_BTN-1:0] btn_out;
   logic [NUM_BTN-1:0] press_evt;
   logic [NUM_BTN-1:0] release_evt;

`ifdef BTN_TURBO_EN
   modport master (output btn_raw, gate, socd_mode, no_diagonal, turbo_mask, turbo_half,
                   input  btn_out, press_evt, release_evt);
   modport slave  (input  btn_raw, gate, socd_mode, no_diagonal, turbo_mask, turbo_half,
                   output btn_out, press_evt, release_evt);
`else
   modport master (output btn_raw, gate, socd_mode, no_diagonal,
                   input  btn_out, press_evt, release_evt);
   modport slave  (input  btn_raw, gate, socd_mode, no_diagonal,
                   output btn_out, press_evt, release_evt);
`endif
endinterface

// File: rtl/btn_conditioner_debounce.sv
// One button channel: 2-FF synchroniser followed by a symmetric
// press/release debounce counter and the accepted stable level.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 14,
   parameter int DEBOUNCE_W   = 4
) (
   input  logic pclk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_stable
);
   localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_CYC - 1);

   logic                  r_sync1;
   logic                  r_sync2;
   logic [DEBOUNCE_W-1:0] r_cnt;
   logic                  r_stable;

   // The flip happens on the DEBOUNCE_CYC-th consecutive disagreeing cycle
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + DEBOUNCE_W'(1);
         end
      end
   end

   assign o_stable = r_stable;
endmodule

// File: rtl/btn_conditioner.sv
// Button conditioner top: per-channel debounce, D-pad SOCD owners, no-diagonal
// lock, optional autofire (BTN_TURBO_EN) and press/release event pulses.
module btn_conditioner
   import btn_cond_pkg::*;
#(
   parameter int NUM_BTN      = 8,
   parameter int DEBOUNCE_CYC = 14,
   parameter int DEBOUNCE_W   = 4
`ifdef BTN_TURBO_EN
   , parameter int TURBO_W    = 16
`endif
) (
   input logic               pclk,
   input logic               reset_n,
   btn_conditioner_if.slave  bus
);
   logic [NUM_BTN-1:0] w_raw_gated;
   logic [NUM_BTN-1:0] w_stable;
   logic [NUM_BTN-1:0] w_res;
   logic [NUM_BTN-1:0] w_out_nx;
   logic [1:0]         w_v;
   logic [1:0]         w_h;
   logic               w_drop_v;
   logic               w_drop_h;
   logic               w_v_prev;
   logic               w_h_prev;
   owner_e             w_own_v_nx;
   owner_e             w_own_h_nx;

   logic [3:0]         r_stable_d;
   owner_e             r_own_v;
   owner_e             r_own_h;
   logic [NUM_BTN-1:0] r_res;
   logic [NUM_BTN-1:0] r_btn_out;
   logic [NUM_BTN-1:0] r_press;
   logic [NUM_BTN-1:0] r_release;

   assign w_raw_gated = bus.btn_raw & {NUM_BTN{bus.gate}};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .DEBOUNCE_W(DEBOUNCE_W)) u_db (
         .pclk     (pclk),
         .reset_n  (reset_n),
         .i_raw    (w_raw_gated[g]),
         .o_stable (w_stable[g])
      );
   end

   assign w_v_prev = r_res[BTN_UP]   | r_res[BTN_DOWN];
   assign w_h_prev = r_res[BTN_LEFT] | r_res[BTN_RIGHT];

   // SOCD per axis, then the no-diagonal lock favouring the axis already shown
   always_comb begin
      w_own_v_nx = owner_next(w_stable[BTN_UP], w_stable[BTN_DOWN],
                              w_stable[BTN_UP] & ~r_stable_d[BTN_UP],
                              w_stable[BTN_DOWN] & ~r_stable_d[BTN_DOWN],
                              bus.socd_mode, r_own_v);
      w_own_h_nx = owner_next(w_stable[BTN_LEFT], w_stable[BTN_RIGHT],
                              w_stable[BTN_LEFT] & ~r_stable_d[BTN_LEFT],
                              w_stable[BTN_RIGHT] & ~r_stable_d[BTN_RIGHT],
                              bus.socd_mode, r_own_h);
      w_v = axis_resolve(w_stable[BTN_UP], w_stable[BTN_DOWN], w_own_v_nx, bus.socd_mode, 1'b1);
      w_h = axis_resolve(w_stable[BTN_LEFT], w_stable[BTN_RIGHT], w_own_h_nx, bus.socd_mode, 1'b0);
      w_drop_v = 1'b0;
      w_drop_h = 1'b0;
      if (bus.no_diagonal && (|w_v) && (|w_h)) begin
         if (w_h_prev && !w_v_prev) w_drop_v = 1'b1;
         else                       w_drop_h = 1'b1;
      end else begin
         w_drop_v = 1'b0;
         w_drop_h = 1'b0;
      end
      w_res            = w_stable;
      w_res[BTN_UP]    = w_v[0] & ~w_drop_v;
      w_res[BTN_DOWN]  = w_v[1] & ~w_drop_v;
      w_res[BTN_LEFT]  = w_h[0] & ~w_drop_h;
      w_res[BTN_RIGHT] = w_h[1] & ~w_drop_h;
   end

`ifdef BTN_TURBO_EN
   logic [TURBO_W-1:0] r_tcnt [NUM_BTN];
   logic [NUM_BTN-1:0] r_phase;
   logic [TURBO_W-1:0] w_tcnt_nx [NUM_BTN];
   logic [NUM_BTN-1:0] w_phase_nx;
   logic [TURBO_W-1:0] w_half_m1;

   assign w_half_m1 = (bus.turbo_half == '0) ? '0 : bus.turbo_half - TURBO_W'(1);

   // Phase restarts high on each resolved press and toggles every turbo_half cycles
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         w_tcnt_nx[i]  = '0;
         w_phase_nx[i] = 1'b0;
         if (w_res[i] && !r_res[i]) begin
            w_phase_nx[i] = 1'b1;
         end else if (w_res[i]) begin
            if (r_tcnt[i] >= w_half_m1) begin
               w_phase_nx[i] = ~r_phase[i];
            end else begin
               w_tcnt_nx[i]  = r_tcnt[i] + TURBO_W'(1);
               w_phase_nx[i] = r_phase[i];
            end
         end else begin
            w_phase_nx[i] = 1'b0;
         end
      end
      w_out_nx = w_res & (~bus.turbo_mask | w_phase_nx);
   end

   // Autofire phase state
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_BTN; i++) r_tcnt[i] <= '0;
         r_phase <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) r_tcnt[i] <= w_tcnt_nx[i];
         r_phase <= w_phase_nx;
      end
   end
`else
   assign w_out_nx = w_res;
`endif

   // Resolved stage, outputs and edge pulses all update together
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable_d <= 4'b0000;
         r_own_v    <= OWN_NONE;
         r_own_h    <= OWN_NONE;
         r_res      <= '0;
         r_btn_out  <= '0;
         r_press    <= '0;
         r_release  <= '0;
      end else begin
         r_stable_d <= w_stable[3:0];
         r_own_v    <= w_own_v_nx;
         r_own_h    <= w_own_h_nx;
         r_res      <= w_res;
         r_btn_out  <= w_out_nx;
         r_press    <= w_out_nx & ~r_btn_out;
         r_release  <= ~w_out_nx & r_btn_out;
      end
   end

   assign bus.btn_out     = r_btn_out;
   assign bus.press_evt   = r_press;
   assign bus.release_evt = r_release;
endmodule
